mi_seq: RTL and testbench
=========================

Name: mi_seq

Overview:
Parametrised multicycle instruction sequencer. It sits between fetch and decode.
- Ordinary instructions pass through with one registered cycle of latency.
- Custom-0 "multi-op" instructions are expanded into up to MAX_UOPS consecutive RV32I R-type micro-ops.
- pc_en stalls the front end while an expansion is in progress.
- Adds pipeline stall (en), redirect flush, micro-op index and valid outputs.

Parameters:
WIDTH, 32, PC and instruction width (instruction fields assume 32).
MAX_UOPS, 4, maximum micro-ops per multi-op instruction (2..16).
CNT_W, $clog2(MAX_UOPS), width of the count field and of uop_idx (derived, not overridden).

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
en  input  1  advance enable; 0 = stall, all registers hold
flush  input  1  synchronous redirect; abort any expansion
pc_in  input  WIDTH  PC of instr_in
instr_in  input  WIDTH  fetched instruction
pc_en  output  1  1 = front end may advance PC / present next instruction
pc_out  output  WIDTH  PC associated with instr_out
instr_out  output  WIDTH  instruction or micro-op to decode
valid  output  1  instr_out is meaningful
uop_idx  output  CNT_W  index of current micro-op (0 for pass-through)
state  output  2  FSM state: 00 IDLE, 01 EXPAND

Behaviour:
- Multi-op encoding: opcode 7'b0001011.
  - funct3 selects the op, emitted with the same funct3 as an R-type: 000 ADD, 100 XOR, 110 OR, 111 AND. Other funct3 values pass through unmodified.
  - funct7[CNT_W-1:0] = count-1; count is clamped to MAX_UOPS.
  - Micro-op i: opcode 0110011, funct7 0, funct3 kept, rd+i, rs1+i, rs2+i. All register indices wrap modulo 32.
- Reset (rst=0 at clk edge), highest priority. Outputs: state IDLE, instr_out 32'h00000013 (NOP), pc_out 0, valid 0, uop_idx 0, pc_en 1. Reset mid-expansion discards remaining micro-ops.
- flush=1 (rst=1): same values as reset. Has priority over en and over instr_in.
- en=0 (no rst/flush): every output and internal register holds its value.
- IDLE, en=1:
  - Non-multi-op: instr_out<=instr_in, pc_out<=pc_in, valid<=1, uop_idx<=0, pc_en<=1.
  - Multi-op with count=1: emit micro-op 0, pc_en<=1, stay IDLE.
  - Multi-op with count>1: latch instr_in and pc_in; emit micro-op 0 with pc_out=pc_in; pc_en<=0; uop_idx<=0; go to EXPAND.
- EXPAND, en=1:
  - Emit micro-op uop_idx+1 with pc_out unchanged; instr_in is ignored.
  - When the emitted index equals count-1: pc_en<=1 and go to IDLE.
  - The first pass-through instruction after expansion appears exactly one cycle after the last micro-op.
- Latency: one cycle from capture edge to instr_out; an N-op instruction occupies N consecutive enabled cycles.
- Simultaneous flush and last micro-op: flush wins (NOP, valid 0).

Optional Feature:
MI_SEQ_SCALAR_EN: when defined, funct7[6]=1 holds rs2 constant across all micro-ops (scalar broadcast), while rd and rs1 still increment. When undefined, funct7[6] is ignored and rs2 always increments.

Test Plan:
- Reset: rst=0 for 2 cycles -> instr_out=0x00000013, pc_out=0, valid=0, pc_en=1, state=00.
- Pass-through: pc_in=4, instr_in=0x002081B3, en=1 -> next cycle instr_out=0x002081B3, pc_out=4, valid=1, pc_en=1, uop_idx=0.
- Expansion: pc_in=8, instr_in=0x0620818B (count 4, ADD, rd=x3, rs1=x1, rs2=x2) -> 4 cycles instr_out = 0x002081B3, 0x00310233, 0x004182B3, 0x00520333. uop_idx=0..3; pc_out=8 throughout; pc_en=0,0,0,1; state=01 until the last op. Then pc_in=12 passes through.
- Stall: en=0 during uop_idx=1 for 3 cycles -> outputs frozen; sequence resumes at uop_idx=2 with no op lost or repeated.
- Flush: flush=1 at uop_idx=1 -> next cycle NOP, valid=0, pc_en=1, state=00; the following instruction passes through normally.
- Wrap and scalar: rd=x31, count 2 -> second op rd=x0. With MI_SEQ_SCALAR_EN and funct7[6]=1 -> rs2 stays x2 in every micro-op.

Source files
------------

// File: rtl/mi_seq.sv
// Multicycle instruction sequencer between fetch and decode: expands custom-0 multi-ops into R-type micro-ops.
// Latency: one registered cycle; an N-op instruction occupies N consecutive enabled cycles.
// Backpressure: en=0 freezes everything, pc_en=0 holds the front end during expansion; MI_SEQ_SCALAR_EN enables rs2 broadcast.
module mi_seq #(
    parameter int WIDTH    = 32,
    parameter int MAX_UOPS = 4,
    localparam int CNT_W   = $clog2(MAX_UOPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] instr_in,
    output logic             pc_en,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] instr_out,
    output logic             valid,
    output logic [CNT_W-1:0] uop_idx,
    output logic [1:0]       state
);

    localparam logic [1:0]       IDLE     = 2'b00;
    localparam logic [1:0]       EXPAND   = 2'b01;
    localparam logic [6:0]       MULTI_OP = 7'b0001011;
    localparam logic [6:0]       R_OP     = 7'b0110011;
    localparam logic [WIDTH-1:0] NOP      = WIDTH'(32'h0000_0013);
    localparam logic [CNT_W:0]   MAX_CNT  = (CNT_W+1)'(MAX_UOPS);
    localparam logic [CNT_W-1:0] LAST_MAX = CNT_W'(MAX_UOPS - 1);

    logic [2:0]       lat_f3;
    logic [4:0]       lat_rd, lat_rs1, lat_rs2;
    logic             lat_rs2_inc;
    logic [CNT_W-1:0] last_idx;

    logic             in_multi;
    logic [CNT_W-1:0] in_cnt_field;
    logic [CNT_W-1:0] in_last;
    logic             in_rs2_inc;
    logic [CNT_W-1:0] nxt_idx;

    function automatic logic [WIDTH-1:0] make_uop(
        input logic [2:0]       f3,
        input logic [4:0]       rd,
        input logic [4:0]       rs1,
        input logic [4:0]       rs2,
        input logic             rs2_inc,
        input logic [CNT_W-1:0] idx
    );
        logic [4:0] off;
        logic [4:0] rd_i, rs1_i, rs2_i;
        off   = 5'(idx);
        // 5-bit adds give the modulo-32 register wrap for free
        rd_i  = rd + off;
        rs1_i = rs1 + off;
        rs2_i = rs2_inc ? rs2 + off : rs2;
        return WIDTH'({7'b0, rs2_i, rs1_i, f3, rd_i, R_OP});
    endfunction

    always_comb begin
        in_multi = (instr_in[6:0] == MULTI_OP) &&
                   ((instr_in[14:12] == 3'b000) || (instr_in[14:12] == 3'b100) ||
                    (instr_in[14:12] == 3'b110) || (instr_in[14:12] == 3'b111));
        in_cnt_field = instr_in[25 +: CNT_W];
        in_last      = ({1'b0, in_cnt_field} >= MAX_CNT) ? LAST_MAX : in_cnt_field;
        nxt_idx      = uop_idx + CNT_W'(1);
    end

`ifdef MI_SEQ_SCALAR_EN
    assign in_rs2_inc = ~instr_in[31];
`else
    assign in_rs2_inc = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            state       <= IDLE;
            instr_out   <= NOP;
            pc_out      <= '0;
            valid       <= 1'b0;
            uop_idx     <= '0;
            pc_en       <= 1'b1;
            lat_f3      <= '0;
            lat_rd      <= '0;
            lat_rs1     <= '0;
            lat_rs2     <= '0;
            lat_rs2_inc <= 1'b1;
            last_idx    <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    pc_out  <= pc_in;
                    valid   <= 1'b1;
                    uop_idx <= '0;
                    if (in_multi) begin
                        instr_out   <= make_uop(instr_in[14:12], instr_in[11:7], instr_in[19:15],
                                                instr_in[24:20], in_rs2_inc, '0);
                        lat_f3      <= instr_in[14:12];
                        lat_rd      <= instr_in[11:7];
                        lat_rs1     <= instr_in[19:15];
                        lat_rs2     <= instr_in[24:20];
                        lat_rs2_inc <= in_rs2_inc;
                        last_idx    <= in_last;
                        if (in_last == '0) begin
                            pc_en <= 1'b1;
                            state <= IDLE;
                        end else begin
                            pc_en <= 1'b0;
                            state <= EXPAND;
                        end
                    end else begin
                        instr_out <= instr_in;
                        pc_en     <= 1'b1;
                    end
                end
                EXPAND: begin
                    instr_out <= make_uop(lat_f3, lat_rd, lat_rs1, lat_rs2, lat_rs2_inc, nxt_idx);
                    uop_idx   <= nxt_idx;
                    valid     <= 1'b1;
                    if (nxt_idx == last_idx) begin
                        pc_en <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    pc_en <= 1'b1;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mi_seq.sv
// Self-checking bench for mi_seq: a front-end model feeds instructions, a scoreboard holds expected decode-side outputs.
module tb_mi_seq;

    localparam int WIDTH    = 32;
    localparam int MAX_UOPS = 4;
    localparam int CNT_W    = 2;

    logic             clk = 1'b0;
    logic             rst, en, flush;
    logic [WIDTH-1:0] pc_in, instr_in;
    logic             pc_en, valid;
    logic [WIDTH-1:0] pc_out, instr_out;
    logic [CNT_W-1:0] uop_idx;
    logic [1:0]       state;

    mi_seq #(.WIDTH(WIDTH), .MAX_UOPS(MAX_UOPS)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .pc_in(pc_in), .instr_in(instr_in),
        .pc_en(pc_en), .pc_out(pc_out), .instr_out(instr_out),
        .valid(valid), .uop_idx(uop_idx), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  idx;
        logic        valid;
        logic        pc_en;
        logic [1:0]  state;
    } exp_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fet_t;

    exp_t        sb[$];
    fet_t        fq[$];
    exp_t        last;
    exp_t        nop_e;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] fill_pc  = 32'h0000_1000;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic bit is_multi(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        return (ins[6:0] == 7'h0B) && (f3 == 3'd0 || f3 == 3'd4 || f3 == 3'd6 || f3 == 3'd7);
    endfunction

    function automatic int op_count(input logic [31:0] ins);
        int n;
        n = int'(ins[26:25]) + 1;
        return (n > MAX_UOPS) ? MAX_UOPS : n;
    endfunction

    function automatic logic [31:0] ref_uop(input logic [31:0] ins, input int i);
        logic [4:0] rd, rs1, rs2;
        rd  = 5'((int'(ins[11:7]) + i) % 32);
        rs1 = 5'((int'(ins[19:15]) + i) % 32);
        rs2 = 5'((int'(ins[24:20]) + i) % 32);
`ifdef MI_SEQ_SCALAR_EN
        if (ins[31]) rs2 = ins[24:20];
`endif
        return mk(7'd0, rs2, rs1, ins[14:12], rd, 7'h33);
    endfunction

    task automatic push_exp(input fet_t f);
        exp_t e;
        int   n;
        if (is_multi(f.instr)) begin
            n = op_count(f.instr);
            for (int i = 0; i < n; i++) begin
                e.instr = ref_uop(f.instr, i);
                e.pc    = f.pc;
                e.idx   = 2'(i);
                e.valid = 1'b1;
                e.pc_en = (i == n - 1);
                e.state = (i == n - 1) ? 2'b00 : 2'b01;
                sb.push_back(e);
            end
        end else begin
            e = '{instr: f.instr, pc: f.pc, idx: 2'd0, valid: 1'b1, pc_en: 1'b1, state: 2'b00};
            sb.push_back(e);
        end
    endtask

    task automatic compare(input string tag, input exp_t e);
        chk({tag, ".instr"}, instr_out, e.instr);
        chk({tag, ".pc"}, pc_out, e.pc);
        chk({tag, ".idx"}, 32'(uop_idx), 32'(e.idx));
        chk({tag, ".valid"}, 32'(valid), 32'(e.valid));
        chk({tag, ".pc_en"}, 32'(pc_en), 32'(e.pc_en));
        chk({tag, ".state"}, 32'(state), 32'(e.state));
    endtask

    // One clock: the front end offers its head instruction; it is consumed only when the sequencer is idle.
    task automatic step(input bit e, input bit f, input bit r, input string tag);
        fet_t h;
        bit   acc;
        @(negedge clk);
        if (fq.size() == 0) begin
            fq.push_back({fill_pc, 32'h0000_0013});
            fill_pc += 4;
        end
        h        = fq[0];
        pc_in    = h.pc;
        instr_in = h.instr;
        en       = e;
        flush    = f;
        rst      = !r;
        acc      = e && !f && !r && last.pc_en;
        if (acc) begin
            void'(fq.pop_front());
            push_exp(h);
        end
        @(posedge clk);
        #1;
        if (r || f) begin
            sb.delete();
            last = nop_e;
            compare({tag, ".clr"}, last);
        end else if (e) begin
            if (sb.size() != 0) last = sb.pop_front();
            compare(tag, last);
        end else begin
            compare({tag, ".hold"}, last);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] rpc;
        nop_e    = '{instr: 32'h13, pc: 32'd0, idx: 2'd0, valid: 1'b0, pc_en: 1'b1, state: 2'b00};
        last     = nop_e;
        rst      = 1'b0;
        en       = 1'b0;
        flush    = 1'b0;
        pc_in    = '0;
        instr_in = '0;

        step(0, 0, 1, "reset");
        step(0, 0, 1, "reset");

        fq.push_back({32'd4, 32'h002081B3});
        fq.push_back({32'd8, 32'h0620818B});
        fq.push_back({32'd12, mk(7'd0, 5'd5, 5'd3, 3'd0, 5'd7, 7'h33)});
        for (int i = 0; i < 7; i++) step(1, 0, 0, "basic");

        fq.push_back({32'd16, 32'h0620818B});
        fq.push_back({32'd20, mk(7'd0, 5'd1, 5'd2, 3'd4, 5'd9, 7'h33)});
        step(1, 0, 0, "stall");
        step(1, 0, 0, "stall");
        for (int i = 0; i < 3; i++) step(0, 0, 0, "stall");
        for (int i = 0; i < 5; i++) step(1, 0, 0, "stall");

        fq.push_back({32'd24, mk(7'h03, 5'd2, 5'd1, 3'b100, 5'd3, 7'h0B)});
        fq.push_back({32'd28, mk(7'd0, 5'd4, 5'd4, 3'd0, 5'd4, 7'h33)});
        step(1, 0, 0, "flush");
        step(1, 0, 0, "flush");
        step(1, 1, 0, "flush");
        for (int i = 0; i < 3; i++) step(1, 0, 0, "flush");

        fq.push_back({32'd32, mk(7'h01, 5'd9, 5'd8, 3'b111, 5'd10, 7'h0B)});
        step(1, 0, 0, "flush_last");
        step(1, 1, 0, "flush_last");
        step(1, 0, 0, "flush_last");
        step(1, 0, 0, "flush_last");

        fq.push_back({32'd36, 32'h0620818B});
        step(1, 0, 0, "rst_mid");
        step(1, 0, 0, "rst_mid");
        step(1, 0, 1, "rst_mid");
        step(1, 0, 0, "rst_mid");
        step(1, 0, 0, "rst_mid");

        fq.push_back({32'd40, mk(7'h01, 5'd2, 5'd1, 3'b110, 5'd31, 7'h0B)});
        fq.push_back({32'd44, mk(7'h41, 5'd2, 5'd1, 3'b000, 5'd5, 7'h0B)});
        fq.push_back({32'd48, mk(7'h03, 5'd2, 5'd1, 3'b001, 5'd3, 7'h0B)});
        fq.push_back({32'd52, mk(7'h00, 5'd6, 5'd7, 3'b111, 5'd8, 7'h0B)});
        fq.push_back({32'd56, mk(7'h3F, 5'd30, 5'd29, 3'b100, 5'd28, 7'h0B)});
        for (int i = 0; i < 12; i++) step(1, 0, 0, "edge");

        rpc = 32'h0000_2000;
        for (int i = 0; i < 200; i++) begin
            if (fq.size() < 2) begin
                r = $urandom;
                if ($urandom_range(0, 2) != 0) r[6:0] = 7'h0B;
                fq.push_back({rpc, r});
                rpc += 4;
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 0, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
